systolic_feed_ctrl: RTL and testbench

- Sequencer for the ROWS x COLS systolic PE array.
- On a start command it streams a K-deep operand tile from the weight and activation buffers and skews it onto the array edges.
  - Weights enter the top edge, one lane per column.
  - Activations enter the left edge, one lane per row.
- It drives the array's single origin fire bit, waits for the wavefront to drain, and then pulses done so the output collector can read results.

---
 rtl/systolic_feed_ctrl_if.sv | 35 +++
 rtl/systolic_feed_ctrl.sv | 131 +++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_feed_ctrl_if.sv
// Command, operand-buffer read and array-edge signals of the systolic feed sequencer.
// master = sequencer side, slave = command issuer / buffers / array side.
interface systolic_feed_ctrl_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = 8,
  parameter int KW   = 16,
  parameter int AW   = 10
);
  logic                 start;
  logic [KW-1:0]        k_len;
  logic [AW-1:0]        base_w;
  logic [AW-1:0]        base_a;
  logic                 busy;
  logic                 done;
  logic                 w_rd_en;
  logic [AW-1:0]        w_rd_addr;
  logic [COLS*DW-1:0]   w_rd_data;
  logic                 a_rd_en;
  logic [AW-1:0]        a_rd_addr;
  logic [ROWS*DW-1:0]   a_rd_data;
  logic                 arr_fire;
  logic [COLS*DW-1:0]   arr_w;
  logic [ROWS*DW-1:0]   arr_a;

  modport master (
    input  start, k_len, base_w, base_a, w_rd_data, a_rd_data,
    output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, arr_fire, arr_w, arr_a
  );

  modport slave (
    output start, k_len, base_w, base_a, w_rd_data, a_rd_data,
    input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr, arr_fire, arr_w, arr_a
  );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Streams a K-deep operand tile into a ROWS x COLS systolic array with per-lane skew.
// Optional busy-cycle counter on perf_cycles is enabled by defining SYSTOLA_PERF_CNT_EN.
module systolic_feed_ctrl #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DW    = 8,
  parameter int KW    = 16,
  parameter int AW    = 10,
  parameter int DRAIN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  systolic_feed_ctrl_if.master bus,
  output logic [31:0]          perf_cycles
);

  localparam int FLEN = ROWS + COLS + DRAIN;
  localparam int FW   = $clog2(FLEN + 1);
  localparam int CW   = (KW > FW) ? KW : FW;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] FLOAD = CW'(FLEN - 1);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH, DONE} state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cap_valid;

  // One counter serves both phases: remaining reads in FETCH, remaining drain in FLUSH.
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.k_len != '0) begin
            nxt     = FETCH;
            cnt_nxt = CW'(bus.k_len) - ONE;
          end else begin
            nxt = DONE;
          end
        end
      end
      FETCH: begin
        if (cnt == '0) begin
          nxt     = FLUSH;
          cnt_nxt = FLOAD;
        end else begin
          cnt_nxt = cnt - ONE;
        end
      end
      FLUSH: begin
        if (cnt == '0) nxt = DONE;
        else           cnt_nxt = cnt - ONE;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Control outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.w_rd_en   <= 1'b0;
      bus.a_rd_en   <= 1'b0;
      bus.w_rd_addr <= '0;
      bus.a_rd_addr <= '0;
      cap_valid     <= 1'b0;
      bus.arr_fire  <= 1'b0;
    end else begin
      state        <= nxt;
      cnt          <= cnt_nxt;
      bus.busy     <= (nxt != IDLE);
      bus.done     <= (nxt == DONE);
      bus.w_rd_en  <= (nxt == FETCH);
      bus.a_rd_en  <= (nxt == FETCH);
      cap_valid    <= bus.w_rd_en;
      bus.arr_fire <= cap_valid;
      if (state == IDLE && bus.start) begin
        bus.w_rd_addr <= bus.base_w;
        bus.a_rd_addr <= bus.base_a;
      end else if (state == FETCH && nxt == FETCH) begin
        bus.w_rd_addr <= bus.w_rd_addr + AW'(1);
        bus.a_rd_addr <= bus.a_rd_addr + AW'(1);
      end
    end
  end

  // Lane c is delayed by a c+1 deep register chain; invalid slots enter as zero.
  for (genvar c = 0; c < COLS; c++) begin : g_wlane
    localparam int unsigned DEPTH = c + 1;
    logic [DW-1:0] chain [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned j = 0; j < DEPTH; j++) chain[j] <= '0;
      end else begin
        chain[0] <= cap_valid ? bus.w_rd_data[c*DW +: DW] : '0;
        for (int unsigned j = 1; j < DEPTH; j++) chain[j] <= chain[j-1];
      end
    end
    assign bus.arr_w[c*DW +: DW] = chain[DEPTH-1];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_alane
    localparam int unsigned DEPTH = r + 1;
    logic [DW-1:0] chain [DEPTH];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned j = 0; j < DEPTH; j++) chain[j] <= '0;
      end else begin
        chain[0] <= cap_valid ? bus.a_rd_data[r*DW +: DW] : '0;
        for (int unsigned j = 1; j < DEPTH; j++) chain[j] <= chain[j-1];
      end
    end
    assign bus.arr_a[r*DW +: DW] = chain[DEPTH-1];
  end

`ifdef SYSTOLA_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                perf_cycles <= '0;
    else if (bus.busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
  end
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Scoreboard bench for systolic_feed_ctrl: random commands against a cycle-indexed reference model.
module tb_systolic_feed_ctrl;
  localparam int ROWS = 8, COLS = 8, DW = 8, KW = 16, AW = 10, DRAIN = 2;
  localparam int WW = COLS * DW;
  localparam int VA = ROWS * DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] perf_cycles;

  systolic_feed_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KW(KW), .AW(AW)) bus ();

  systolic_feed_ctrl #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .KW(KW), .AW(AW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .bus(bus), .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Operand buffers: one-cycle read latency, garbage on the bus when not read.
  logic [WW-1:0] wmem [1<<AW];
  logic [VA-1:0] amem [1<<AW];
  always @(posedge clk) begin
    bus.w_rd_data <= bus.w_rd_en ? wmem[bus.w_rd_addr] : WW'({$urandom(), $urandom()});
    bus.a_rd_data <= bus.a_rd_en ? amem[bus.a_rd_addr] : VA'({$urandom(), $urandom()});
  end

  typedef struct { int c; logic [AW-1:0] wa; logic [AW-1:0] aa; } rd_t;
  rd_t           rdq[$];
  int            doneq[$];
  logic [WW-1:0] exp_w[int];
  logic [VA-1:0] exp_a[int];
  bit            exp_fire[int];
  int busy_from = 1, busy_until = 0, perf_exp = 0;
  int checks = 0, passed = 0;
  bit mon_en = 1'b0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endfunction

  function automatic void put_w(int t, int c, logic [DW-1:0] v);
    logic [WW-1:0] tmp = exp_w.exists(t) ? exp_w[t] : '0;
    tmp[c*DW +: DW] = v;
    exp_w[t] = tmp;
  endfunction

  function automatic void put_a(int t, int r, logic [DW-1:0] v);
    logic [VA-1:0] tmp = exp_a.exists(t) ? exp_a[t] : '0;
    tmp[r*DW +: DW] = v;
    exp_a[t] = tmp;
  endfunction

  // Start accepted in cycle c0 only when idle; derives every future event of the command.
  function automatic void model_cmd(int c0, int k, logic [AW-1:0] bw, logic [AW-1:0] ba);
    int d;
    if (c0 <= busy_until) return;
    busy_from = c0 + 1;
    if (k == 0) d = c0 + 1;
    else begin
      d = c0 + k + ROWS + COLS + DRAIN + 1;
      for (int n = 0; n < k; n++) begin
        logic [AW-1:0] wa = bw + AW'(n);
        logic [AW-1:0] aa = ba + AW'(n);
        rdq.push_back('{c0 + 1 + n, wa, aa});
        exp_fire[c0 + 3 + n] = 1'b1;
        for (int c = 0; c < COLS; c++) put_w(c0 + 3 + n + c, c, wmem[wa][c*DW +: DW]);
        for (int r = 0; r < ROWS; r++) put_a(c0 + 3 + n + r, r, amem[aa][r*DW +: DW]);
      end
    end
    busy_until = d;
    doneq.push_back(d);
  endfunction

  // Reset sampled at the end of cycle r wipes everything expected after r.
  function automatic void model_rst(int r);
    rd_t keep[$];
    int  dkeep[$];
    if (busy_until > r) busy_until = r;
    foreach (rdq[i]) if (rdq[i].c <= r) keep.push_back(rdq[i]);
    rdq = keep;
    foreach (doneq[i]) if (doneq[i] <= r) dkeep.push_back(doneq[i]);
    doneq = dkeep;
    for (int t = r + 1; t < r + 400; t++) begin
      if (exp_w.exists(t)) exp_w.delete(t);
      if (exp_a.exists(t)) exp_a.delete(t);
      if (exp_fire.exists(t)) exp_fire.delete(t);
    end
  endfunction

  always @(negedge clk) begin : monitor
    bit be;
    rd_t e;
    int d;
    if (mon_en) begin
      be = (cyc >= busy_from) && (cyc <= busy_until);
      chk("busy", 64'(bus.busy), 64'(be));
      if (bus.w_rd_en || bus.a_rd_en) begin
        if (rdq.size() == 0) chk("rd_unexpected", 64'(1), 64'(0));
        else begin
          e = rdq.pop_front();
          chk("rd_cycle", 64'(cyc), 64'(e.c));
          chk("w_rd_en", 64'(bus.w_rd_en), 64'(1));
          chk("a_rd_en", 64'(bus.a_rd_en), 64'(1));
          chk("w_rd_addr", 64'(bus.w_rd_addr), 64'(e.wa));
          chk("a_rd_addr", 64'(bus.a_rd_addr), 64'(e.aa));
        end
      end else if (rdq.size() != 0 && rdq[0].c <= cyc) begin
        chk("rd_missing", 64'(0), 64'(1));
        void'(rdq.pop_front());
      end
      if (bus.done) begin
        if (doneq.size() == 0) chk("done_unexpected", 64'(1), 64'(0));
        else begin
          d = doneq.pop_front();
          chk("done_cycle", 64'(cyc), 64'(d));
        end
      end else if (doneq.size() != 0 && doneq[0] <= cyc) begin
        chk("done_missing", 64'(0), 64'(1));
        void'(doneq.pop_front());
      end
      chk("arr_fire", 64'(bus.arr_fire), 64'(exp_fire.exists(cyc)));
      chk("arr_w", 64'(bus.arr_w), 64'(exp_w.exists(cyc) ? exp_w[cyc] : '0));
      chk("arr_a", 64'(bus.arr_a), 64'(exp_a.exists(cyc) ? exp_a[cyc] : '0));
`ifdef SYSTOLA_PERF_CNT_EN
      chk("perf_cycles", 64'(perf_cycles), 64'(perf_exp));
`else
      chk("perf_cycles", 64'(perf_cycles), 64'(0));
`endif
      if (rst) perf_exp = 0;
      else if (be) perf_exp++;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(int k, logic [AW-1:0] bw, logic [AW-1:0] ba);
    bus.start  = 1'b1;
    bus.k_len  = KW'(k);
    bus.base_w = bw;
    bus.base_a = ba;
    model_cmd(cyc, k, bw, ba);
    tick(1);
    bus.start  = 1'b0;
    bus.k_len  = KW'($urandom());
    bus.base_w = AW'($urandom());
    bus.base_a = AW'($urandom());
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    model_rst(cyc);
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      wmem[i] = WW'({$urandom(), $urandom()});
      amem[i] = VA'({$urandom(), $urandom()});
    end
    for (int n = 0; n < 4; n++)
      for (int c = 0; c < COLS; c++) wmem['h10 + n][c*DW +: DW] = DW'(16 * n + c);
    bus.start  = 1'b0;
    bus.k_len  = '0;
    bus.base_w = '0;
    bus.base_a = '0;
    tick(3);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick(20);

    issue(4, AW'('h10), AW'('h20));
    tick(4);
    issue(4, AW'($urandom()), AW'($urandom()));
    tick(18);
    issue(4, AW'('h3FE), AW'('h3FC));
    tick(30);

    issue(0, AW'($urandom()), AW'($urandom()));
    tick(5);

    issue(8, AW'($urandom()), AW'($urandom()));
    tick(5);
    rst_pulse();
    tick(3);
    issue(8, AW'($urandom()), AW'($urandom()));
    tick(40);

    repeat (25) begin
      issue($urandom_range(0, 20), AW'($urandom()), AW'($urandom()));
      tick($urandom_range(0, 40));
    end
    tick(60);
    chk("rd_queue_drained", 64'(rdq.size()), 64'(0));
    chk("done_queue_drained", 64'(doneq.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
